// File: rtl/gpr_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : gpr_file_mp
// Brief    : Parametrised multi-port general-purpose register file with
//            fixed-priority write ports, registered read ports, optional
//            hard-wired zero register and a per-register busy scoreboard.
//            Optional macro GPR_BYPASS_EN selects write-first reads
//            (undefined: read-first).
// Revision : 1.0 - initial release
// ============================================================================
module gpr_file_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int RD_PORTS = 3,
    parameter int WR_PORTS = 2,
    parameter int ZERO_REG = 0,
    localparam int AW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [RD_PORTS-1:0]        rd_en,
    input  logic [RD_PORTS*AW-1:0]     rd_addr,
    output logic [RD_PORTS*DATA_W-1:0] rd_data,
    output logic [RD_PORTS-1:0]        rd_valid,
    output logic [RD_PORTS-1:0]        rd_busy,
    input  logic [WR_PORTS-1:0]        wr_en,
    input  logic [WR_PORTS*AW-1:0]     wr_addr,
    input  logic [WR_PORTS*DATA_W-1:0] wr_data,
    input  logic                       bsy_set_en,
    input  logic [AW-1:0]              bsy_set_addr,
    output logic [NUM_REGS-1:0]        busy
);

    logic [DATA_W-1:0]   r_regs     [NUM_REGS];
    logic [DATA_W-1:0]   w_regs_nxt [NUM_REGS];
    logic [NUM_REGS-1:0] w_busy_nxt;

    // Post-edge register contents: later write ports override earlier ones
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_regs_nxt[i] = r_regs[i];
        end
        for (int w = 0; w < WR_PORTS; w++) begin
            if (wr_en[w]) begin
                w_regs_nxt[wr_addr[w*AW +: AW]] = wr_data[w*DATA_W +: DATA_W];
            end
        end
        if (ZERO_REG != 0) begin
            w_regs_nxt[0] = '0;
        end
    end

    // Post-edge scoreboard: writebacks clear, a new producer's set wins
    always_comb begin
        w_busy_nxt = busy;
        for (int w = 0; w < WR_PORTS; w++) begin
            if (wr_en[w]) begin
                w_busy_nxt[wr_addr[w*AW +: AW]] = 1'b0;
            end
        end
        if (bsy_set_en) begin
            w_busy_nxt[bsy_set_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            w_busy_nxt[0] = 1'b0;
        end
    end

    // Register array storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= w_regs_nxt[i];
            end
        end
    end

    // Scoreboard register, driven straight to the busy output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= w_busy_nxt;
        end
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [AW-1:0]     w_addr;
        logic [DATA_W-1:0] w_data;
        logic [DATA_W-1:0] r_data;
        logic              r_valid;
        logic              r_busy;

        assign w_addr = rd_addr[p*AW +: AW];
`ifdef GPR_BYPASS_EN
        // Write-first: same-cycle writes are forwarded to the read
        assign w_data = w_regs_nxt[w_addr];
`else
        // Read-first: the read sees the contents before this edge's writes
        assign w_data = r_regs[w_addr];
`endif

        // Registered read port; data and busy hold while the port is idle
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_data  <= '0;
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                r_valid <= rd_en[p];
                if (rd_en[p]) begin
                    r_data <= w_data;
                    r_busy <= w_busy_nxt[w_addr];
                end
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = r_data;
        assign rd_valid[p]                 = r_valid;
        assign rd_busy[p]                  = r_busy;
    end

endmodule
`default_nettype wire

// File: tb/tb_gpr_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpr_file_mp
// Brief    : Scoreboard bench for gpr_file_mp. Two instances (ZERO_REG=0 and
//            ZERO_REG=1) share one randomized/directed stimulus stream and are
//            checked against an array-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpr_file_mp;

    logic        clk;
    logic        rst;
    logic [2:0]  rd_en;
    logic [11:0] rd_addr;
    logic [1:0]  wr_en;
    logic [7:0]  wr_addr;
    logic [63:0] wr_data;
    logic        bsy_set_en;
    logic [3:0]  bsy_set_addr;

    logic [95:0] rd_data_z0,  rd_data_z1;
    logic [2:0]  rd_valid_z0, rd_valid_z1;
    logic [2:0]  rd_busy_z0,  rd_busy_z1;
    logic [15:0] busy_z0,     busy_z1;

    gpr_file_mp #(.ZERO_REG(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_z0),
        .rd_valid(rd_valid_z0), .rd_busy(rd_busy_z0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .bsy_set_en(bsy_set_en), .bsy_set_addr(bsy_set_addr), .busy(busy_z0)
    );

    gpr_file_mp #(.ZERO_REG(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_z1),
        .rd_valid(rd_valid_z1), .rd_busy(rd_busy_z1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .bsy_set_en(bsy_set_en), .bsy_set_addr(bsy_set_addr), .busy(busy_z1)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic [2:0]  en;
        logic [95:0] data;
        logic [2:0]  bsy;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] m_regs [2][16];
    logic [15:0] m_busy [2];
    logic [31:0] m_hold [2][3];
    int          cyc;
    int          checks;
    int          failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic model_clear();
        for (int z = 0; z < 2; z++) begin
            for (int i = 0; i < 16; i++) m_regs[z][i] = '0;
            m_busy[z] = '0;
            for (int p = 0; p < 3; p++) m_hold[z][p] = '0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic idle_in();
        rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        bsy_set_en = 1'b0; bsy_set_addr = '0;
    endtask

    // Apply current inputs for one clock: predict reads, commit model at the edge,
    // return at the following falling edge.
    task automatic cyc_go();
        logic [31:0] post [2][16];
        logic [15:0] nb [2];
        logic [3:0]  a;
        exp_t        e;
        for (int z = 0; z < 2; z++) begin
            for (int i = 0; i < 16; i++) post[z][i] = m_regs[z][i];
            nb[z] = m_busy[z];
            for (int w = 0; w < 2; w++) begin
                if (wr_en[w]) begin
                    a = wr_addr[w*4 +: 4];
                    if (!(z == 1 && a == 4'd0)) post[z][a] = wr_data[w*32 +: 32];
                    nb[z][a] = 1'b0;
                end
            end
            if (bsy_set_en && !(z == 1 && bsy_set_addr == 4'd0)) nb[z][bsy_set_addr] = 1'b1;
            if (rd_en != 3'b000) begin
                e.cyc = 32'(cyc + 1);
                e.en  = rd_en;
                e.bsy = '0;
                for (int p = 0; p < 3; p++) begin
                    if (rd_en[p]) begin
                        a = rd_addr[p*4 +: 4];
`ifdef GPR_BYPASS_EN
                        m_hold[z][p] = post[z][a];
`else
                        m_hold[z][p] = m_regs[z][a];
`endif
                        e.bsy[p] = nb[z][a];
                    end
                    e.data[p*32 +: 32] = m_hold[z][p];
                end
                if (z == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
        @(posedge clk);
        for (int z = 0; z < 2; z++) begin
            for (int i = 0; i < 16; i++) m_regs[z][i] = post[z][i];
            m_busy[z] = nb[z];
        end
        @(negedge clk);
    endtask

    // Asynchronous reset asserted in the middle of the low clock phase
    task automatic reset_mid();
        #2 rst = 1'b1;
        model_clear();
        #1;
        chk("rst_busy0", 32'(busy_z0), 32'h0);
        chk("rst_busy1", 32'(busy_z1), 32'h0);
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("rst_data0_p%0d", p), rd_data_z0[p*32 +: 32], 32'h0);
            chk($sformatf("rst_data1_p%0d", p), rd_data_z1[p*32 +: 32], 32'h0);
        end
        chk("rst_valid0", 32'(rd_valid_z0), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_in();
        cyc_go();
        chk("valid_after_rst", 32'(rd_valid_z0), 32'h0);
    endtask

    task automatic mon(input int z, input logic [2:0] v, input logic [95:0] d,
                       input logic [2:0] b, input logic [15:0] bv);
        exp_t e;
        int   n;
        chk($sformatf("busy_vec_z%0d", z), 32'(bv), 32'(m_busy[z]));
        if (v != 3'b000) begin
            n = (z == 0) ? q0.size() : q1.size();
            if (n == 0) begin
                chk($sformatf("unexpected_valid_z%0d", z), 32'(v), 32'h0);
            end else begin
                if (z == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("rd_cycle_z%0d", z), 32'(cyc), e.cyc);
                chk($sformatf("rd_valid_z%0d", z), 32'(v), 32'(e.en));
                for (int p = 0; p < 3; p++) begin
                    chk($sformatf("rd_data_z%0d_p%0d", z, p), d[p*32 +: 32], e.data[p*32 +: 32]);
                    if (e.en[p])
                        chk($sformatf("rd_busy_z%0d_p%0d", z, p), 32'(b[p]), 32'(e.bsy[p]));
                end
            end
        end
    endtask

    // Monitor: samples 1 time unit after every rising edge
    always @(posedge clk) begin
        cyc++;
        #1;
        mon(0, rd_valid_z0, rd_data_z0, rd_busy_z0, busy_z0);
        mon(1, rd_valid_z1, rd_data_z1, rd_busy_z1, busy_z1);
    end

    initial begin
        checks = 0; failures = 0; cyc = 0;
        rst = 1'b1;
        idle_in();
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc_go();
        chk("valid_idle", 32'(rd_valid_z0), 32'h0);

        // Reset mid-operation, then read back r5
        idle_in(); wr_en = 2'b01; wr_addr = 8'h05; wr_data = 64'h0000_0000_DEAD_BEEF;
        bsy_set_en = 1'b1; bsy_set_addr = 4'd5;
        cyc_go();
        reset_mid();
        idle_in(); rd_en = 3'b001; rd_addr = 12'h005;
        cyc_go();
        chk("r5_after_rst", rd_data_z0[31:0], 32'h0);
        chk("r5_valid", 32'(rd_valid_z0), 32'h1);
        idle_in();
        cyc_go();
        chk("r5_valid_pulse", 32'(rd_valid_z0), 32'h0);

        // Basic write then triple read
        idle_in(); wr_en = 2'b01; wr_addr = 8'h03; wr_data = 64'h0000_0000_1234_5678;
        cyc_go();
        idle_in(); rd_en = 3'b111; rd_addr = 12'h333;
        cyc_go();
        chk("basic_valid", 32'(rd_valid_z0), 32'h7);
        for (int p = 0; p < 3; p++)
            chk($sformatf("basic_p%0d", p), rd_data_z0[p*32 +: 32], 32'h1234_5678);

        // Write collision: port 1 wins
        idle_in(); wr_en = 2'b11; wr_addr = 8'h77; wr_data = 64'h2222_2222_1111_1111;
        cyc_go();
        idle_in(); rd_en = 3'b010; rd_addr = 12'h070;
        cyc_go();
        chk("collision", rd_data_z0[63:32], 32'h2222_2222);

        // Read during write
        idle_in(); wr_en = 2'b01; wr_addr = 8'h02; wr_data = 64'h0000_0000_AAAA_0000;
        cyc_go();
        idle_in(); wr_en = 2'b01; wr_addr = 8'h02; wr_data = 64'h0000_0000_BBBB_0000;
        rd_en = 3'b001; rd_addr = 12'h002;
        cyc_go();
`ifdef GPR_BYPASS_EN
        chk("rdw", rd_data_z0[31:0], 32'hBBBB_0000);
`else
        chk("rdw", rd_data_z0[31:0], 32'hAAAA_0000);
`endif

        // Scoreboard
        idle_in(); bsy_set_en = 1'b1; bsy_set_addr = 4'd9;
        cyc_go();
        chk("busy9_set", 32'(busy_z0[9]), 32'h1);
        idle_in(); rd_en = 3'b100; rd_addr = 12'h900;
        cyc_go();
        chk("rd_busy9", 32'(rd_busy_z0[2]), 32'h1);
        idle_in(); bsy_set_en = 1'b1; bsy_set_addr = 4'd9; wr_en = 2'b01; wr_addr = 8'h09;
        cyc_go();
        chk("busy9_set_wins", 32'(busy_z0[9]), 32'h1);
        idle_in(); wr_en = 2'b01; wr_addr = 8'h09;
        cyc_go();
        chk("busy9_clear", 32'(busy_z0[9]), 32'h0);

        // Zero register
        idle_in(); wr_en = 2'b10; wr_addr = 8'h00; wr_data = 64'hFFFF_FFFF_0000_0000;
        bsy_set_en = 1'b1; bsy_set_addr = 4'd0;
        cyc_go();
        chk("zr_busy0", 32'(busy_z1[0]), 32'h0);
        chk("nzr_busy0", 32'(busy_z0[0]), 32'h1);
        idle_in(); rd_en = 3'b001; rd_addr = 12'h000;
        cyc_go();
        chk("zr_data", rd_data_z1[31:0], 32'h0);
        chk("zr_rd_busy", 32'(rd_busy_z1[0]), 32'h0);
        chk("nzr_data", rd_data_z0[31:0], 32'hFFFF_FFFF);

        // Randomized traffic with one mid-run reset
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) reset_mid();
            rd_en        = 3'($urandom);
            rd_addr      = 12'($urandom);
            wr_en        = 2'($urandom);
            wr_addr      = 8'($urandom);
            wr_data      = {$urandom(), $urandom()};
            bsy_set_en   = ($urandom_range(0, 2) == 0);
            bsy_set_addr = 4'($urandom);
            cyc_go();
        end
        idle_in();
        cyc_go();
        cyc_go();
        chk("queue_drained_z0", 32'(q0.size()), 32'h0);
        chk("queue_drained_z1", 32'(q1.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
